// File: rtl/fp_result_conditioner.sv
// FP32 multiplier result conditioner: overflow/flush/NaN cleanup behind a 2-entry skid buffer.
// Build option: define FPRC_SAT_MAXFINITE_EN to saturate overflow to max finite instead of infinity.
module fp_result_conditioner #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_result,
  input  logic             in_overflow,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic [2:0]       out_flags,
  input  logic             clr_stats,
  output logic [CNT_W-1:0] ovf_cnt,
  output logic [CNT_W-1:0] zero_cnt,
  output logic [CNT_W-1:0] nan_cnt,
  output logic [CNT_W-1:0] word_cnt
);

`ifdef FPRC_SAT_MAXFINITE_EN
  localparam logic [30:0] OVF_MAG = {8'hFE, 23'h7FFFFF};
`else
  localparam logic [30:0] OVF_MAG = {8'hFF, 23'h000000};
`endif
  localparam logic [31:0] CANON_NAN = 32'h7FC0_0000;

  logic        accept;
  logic [31:0] cls_result;
  logic [2:0]  cls_flags;

  logic        in_ready_reg, in_ready_next;
  logic        out_valid_reg, out_valid_next;
  logic [31:0] out_result_reg, out_result_next;
  logic [2:0]  out_flags_reg, out_flags_next;
  logic        skid_valid_reg, skid_valid_next;
  logic [31:0] skid_result_reg, skid_result_next;
  logic [2:0]  skid_flags_reg, skid_flags_next;

  assign accept = in_valid && in_ready_reg;

  // Priority: overflow, then NaN, then zero/denormal flush, else pass through.
  always_comb begin
    cls_result = in_result;
    cls_flags  = 3'b000;
    if (in_overflow) begin
      cls_result = {in_result[31], OVF_MAG};
      cls_flags  = 3'b001;
    end else if (in_result[30:23] == 8'hFF && in_result[22:0] != 23'h0) begin
      cls_result = CANON_NAN;
      cls_flags  = 3'b100;
    end else if (in_result[30:23] == 8'h00) begin
      cls_result = {in_result[31], 31'h0};
      cls_flags  = 3'b010;
    end
  end

  // The skid slot is only occupied while the output slot is also full.
  always_comb begin
    out_valid_next   = out_valid_reg;
    out_result_next  = out_result_reg;
    out_flags_next   = out_flags_reg;
    skid_valid_next  = skid_valid_reg;
    skid_result_next = skid_result_reg;
    skid_flags_next  = skid_flags_reg;
    if (skid_valid_reg) begin
      if (out_ready) begin
        out_result_next = skid_result_reg;
        out_flags_next  = skid_flags_reg;
        skid_valid_next = 1'b0;
      end
    end else if (accept) begin
      if (!out_valid_reg || out_ready) begin
        out_valid_next  = 1'b1;
        out_result_next = cls_result;
        out_flags_next  = cls_flags;
      end else begin
        skid_valid_next  = 1'b1;
        skid_result_next = cls_result;
        skid_flags_next  = cls_flags;
      end
    end else if (out_valid_reg && out_ready) begin
      out_valid_next = 1'b0;
    end
    in_ready_next = !skid_valid_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      in_ready_reg    <= 1'b1;
      out_valid_reg   <= 1'b0;
      out_result_reg  <= 32'h0;
      out_flags_reg   <= 3'b000;
      skid_valid_reg  <= 1'b0;
      skid_result_reg <= 32'h0;
      skid_flags_reg  <= 3'b000;
    end else begin
      in_ready_reg    <= in_ready_next;
      out_valid_reg   <= out_valid_next;
      out_result_reg  <= out_result_next;
      out_flags_reg   <= out_flags_next;
      skid_valid_reg  <= skid_valid_next;
      skid_result_reg <= skid_result_next;
      skid_flags_reg  <= skid_flags_next;
    end
  end

  assign in_ready   = in_ready_reg;
  assign out_valid  = out_valid_reg;
  assign out_result = out_result_reg;
  assign out_flags  = out_flags_reg;

  // Counter order: 0=ovf, 1=zero, 2=nan, 3=word.
  logic [3:0]       event_vec;
  logic [CNT_W-1:0] cnt_reg [4];

  assign event_vec = {accept, accept && cls_flags[2], accept && cls_flags[1], accept && cls_flags[0]};

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_cnt
      always_ff @(posedge clk) begin
        if (reset || clr_stats) begin
          cnt_reg[gi] <= '0;
        end else if (event_vec[gi] && cnt_reg[gi] != {CNT_W{1'b1}}) begin
          cnt_reg[gi] <= cnt_reg[gi] + CNT_W'(1);
        end
      end
    end
  endgenerate

  assign ovf_cnt  = cnt_reg[0];
  assign zero_cnt = cnt_reg[1];
  assign nan_cnt  = cnt_reg[2];
  assign word_cnt = cnt_reg[3];

endmodule

// File: tb/tb_fp_result_conditioner.sv
// Directed bench for fp_result_conditioner with a scoreboard of expected output words.
module tb_fp_result_conditioner;
  localparam int CNT_W = 4;
`ifdef FPRC_SAT_MAXFINITE_EN
  localparam logic [30:0] OVF_MAG = 31'h7F7F_FFFF;
`else
  localparam logic [30:0] OVF_MAG = 31'h7F80_0000;
`endif

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [31:0]      in_result = 32'h0;
  logic             in_overflow = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [31:0]      out_result;
  logic [2:0]       out_flags;
  logic             clr_stats = 1'b0;
  logic [CNT_W-1:0] ovf_cnt, zero_cnt, nan_cnt, word_cnt;

  int n_cmp = 0;
  int n_fail = 0;
  logic [34:0] sb_q[$];
  logic        hold_prev = 1'b0;
  logic [34:0] prev_word = '0;

  fp_result_conditioner #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result), .in_overflow(in_overflow),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result), .out_flags(out_flags),
    .clr_stats(clr_stats), .ovf_cnt(ovf_cnt), .zero_cnt(zero_cnt), .nan_cnt(nan_cnt), .word_cnt(word_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [34:0] model(input logic [31:0] w, input logic o);
    if (o) return {3'b001, w[31], OVF_MAG};
    if (w[30:23] == 8'hFF && w[22:0] != 23'h0) return {3'b100, 32'h7FC0_0000};
    if (w[30:23] == 8'h00) return {3'b010, w[31], 31'h0};
    return {3'b000, w};
  endfunction

  task automatic chk(input string tag, input logic [34:0] obs, input logic [34:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after posedge; everything is observed on negedge.
  always @(negedge clk) begin
    if (reset) begin
      hold_prev = 1'b0;
    end else begin
      if (hold_prev) chk("stable_while_stalled", {out_flags, out_result}, prev_word);
      if (in_valid && in_ready) sb_q.push_back(model(in_result, in_overflow));
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_output", {out_flags, out_result}, 35'h0_DEAD_BEEF);
        end else begin
          logic [34:0] e;
          e = sb_q.pop_front();
          $display("out word %h flags %b (expect %h flags %b)", out_result, out_flags, e[31:0], e[34:32]);
          chk("out_word", {out_flags, out_result}, e);
        end
      end
      hold_prev = out_valid && !out_ready;
      prev_word = {out_flags, out_result};
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] w, input logic o);
    logic acc;
    int budget;
    in_valid = 1'b1; in_result = w; in_overflow = o;
    acc = 1'b0; budget = 0;
    while (!acc && budget < 50) begin
      @(negedge clk);
      acc = in_ready;
      step();
      budget++;
    end
    if (!acc) chk("send_timeout", 35'd0, 35'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int budget = 0;
    while (sb_q.size() != 0 && budget < 50) begin
      step();
      budget++;
    end
    chk("drain_empty", 35'(sb_q.size()), 35'd0);
  endtask

  initial begin
    // 1: reset values, then a pass-through word with 1-cycle latency
    repeat (3) step();
    reset = 1'b0;
    chk("rst_in_ready", 35'(in_ready), 35'd1);
    chk("rst_out_valid", 35'(out_valid), 35'd0);
    chk("rst_out_word", {out_flags, out_result}, 35'd0);
    chk("rst_cnts", {19'd0, ovf_cnt, zero_cnt, nan_cnt, word_cnt}, 35'd0);
    out_ready = 1'b1;
    in_valid = 1'b1; in_result = 32'h4040_0000; in_overflow = 1'b0;
    @(negedge clk);
    chk("lat_before_edge", 35'(out_valid), 35'd0);
    step();
    in_valid = 1'b0;
    chk("lat_valid", 35'(out_valid), 35'd1);
    chk("lat_word", {out_flags, out_result}, {3'b000, 32'h4040_0000});
    chk("word_cnt_1", 35'(word_cnt), 35'd1);

    // 2-3: classification, including priority of overflow over NaN
    send(32'hC000_0000, 1'b1);
    chk("ovf_cnt_1", 35'(ovf_cnt), 35'd1);
    send(32'h8012_3456, 1'b0);
    send(32'h7F80_0001, 1'b0);
    send(32'h7F80_0000, 1'b0);
    send(32'h7FFF_FFFF, 1'b1);
    chk("zero_cnt_1", 35'(zero_cnt), 35'd1);
    chk("nan_cnt_1", 35'(nan_cnt), 35'd1);
    chk("ovf_cnt_2", 35'(ovf_cnt), 35'd2);
    chk("word_cnt_6", 35'(word_cnt), 35'd6);
    drain();

    // 4: stall with three words in flight
    out_ready = 1'b0;
    in_valid = 1'b1; in_result = 32'h3F80_0000; in_overflow = 1'b0;
    step();
    chk("stall_rdy_after_1", 35'(in_ready), 35'd1);
    in_result = 32'h0000_0001;
    step();
    chk("stall_rdy_after_2", 35'(in_ready), 35'd0);
    in_result = 32'hFFC0_1234;
    step();
    chk("stall_rdy_held", 35'(in_ready), 35'd0);
    chk("stall_out_is_w1", {out_flags, out_result}, {3'b000, 32'h3F80_0000});
    out_ready = 1'b1;
    step();
    chk("release_rdy", 35'(in_ready), 35'd1);
    chk("release_out_w2", {out_flags, out_result}, {3'b010, 32'h0});
    step();
    in_valid = 1'b0;
    chk("release_out_w3", {out_flags, out_result}, {3'b100, 32'h7FC0_0000});
    chk("release_valid", 35'(out_valid), 35'd1);
    step();
    chk("release_empty", 35'(out_valid), 35'd0);
    chk("word_cnt_9", 35'(word_cnt), 35'd9);
    drain();

    // 5: saturation, then clear coincident with an overflow word
    in_valid = 1'b1; in_result = 32'h4000_0000; in_overflow = 1'b1;
    for (int i = 0; i < (1 << CNT_W) + 5; i++) step();
    in_valid = 1'b0;
    chk("ovf_cnt_sat", 35'(ovf_cnt), 35'hF);
    chk("word_cnt_sat", 35'(word_cnt), 35'hF);
    clr_stats = 1'b1;
    in_valid = 1'b1; in_result = 32'h8000_0000;
    step();
    clr_stats = 1'b0; in_valid = 1'b0;
    chk("clr_ovf", 35'(ovf_cnt), 35'd0);
    chk("clr_word", 35'(word_cnt), 35'd0);
    drain();

    // 6: reset with both slots full
    out_ready = 1'b0;
    in_valid = 1'b1; in_result = 32'h4120_0000; in_overflow = 1'b0;
    step();
    in_result = 32'h4130_0000;
    step();
    in_valid = 1'b0;
    chk("full_rdy", 35'(in_ready), 35'd0);
    chk("full_word_cnt", 35'(word_cnt), 35'd2);
    reset = 1'b1;
    step();
    sb_q.delete();
    chk("mrst_out_valid", 35'(out_valid), 35'd0);
    chk("mrst_in_ready", 35'(in_ready), 35'd1);
    chk("mrst_cnts", {19'd0, ovf_cnt, zero_cnt, nan_cnt, word_cnt}, 35'd0);
    chk("mrst_out_word", {out_flags, out_result}, 35'd0);
    reset = 1'b0;
    out_ready = 1'b1;
    send(32'h3F80_0000, 1'b0);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
